// File: rtl/regfile_core.sv
// regfile_core: 32 x WIDTH register file fed by a one-hot write decoder.
// Entry ZERO_REG reads as zero; multi-hot enables are dropped and flagged.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wrEn[31:0]        one-hot write enables (all-zero = idle)
//   writeData         write-back data
//   readRegister1/2   read addresses
//   readData1/2       combinational read data (optional same-cycle bypass)
//   wrErr             sticky multi-hot enable flag
//   wrCount           committed-write counter, wraps at 16 bits
module regfile_core #(
   parameter int WIDTH    = 64,
   parameter int ZERO_REG = 31,
   parameter int BYPASS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      wrEn,
   input  logic [WIDTH-1:0] writeData,
   input  logic [4:0]       readRegister1,
   input  logic [4:0]       readRegister2,
   output logic [WIDTH-1:0] readData1,
   output logic [WIDTH-1:0] readData2,
   output logic             wrErr,
   output logic [15:0]      wrCount
);

   localparam logic [4:0] ZIDX = 5'(ZERO_REG);

   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];
   logic             wr_err_q, wr_err_d;
   logic [15:0]      wr_count_q, wr_count_d;

   logic [4:0]       wr_idx;
   logic             one_hot;
   logic             multi_hot;
   logic             commit;
   logic             byp1, byp2;

   // x & (x-1) clears the lowest set bit: zero result means at most one bit
   assign one_hot   = (wrEn != '0) && ((wrEn & (wrEn - 32'd1)) == '0);
   assign multi_hot = (wrEn != '0) && !one_hot;
   assign commit    = one_hot && (wr_idx != ZIDX);

   // Index is only meaningful when the vector is one-hot
   always_comb begin
      wr_idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (wrEn[i]) wr_idx = 5'(i);
      end
   end

   always_comb begin
      regs_d     = regs_q;
      wr_err_d   = wr_err_q | multi_hot;
      wr_count_d = wr_count_q;
      if (commit) begin
         regs_d[wr_idx] = writeData;
         wr_count_d     = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         wr_err_q   <= 1'b0;
         wr_count_q <= '0;
      end else begin
         for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
         wr_err_q   <= wr_err_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Bypass only on a valid one-hot write; multi-hot never forwards
   assign byp1 = (BYPASS != 0) && one_hot && (wr_idx == readRegister1);
   assign byp2 = (BYPASS != 0) && one_hot && (wr_idx == readRegister2);

   always_comb begin
      if (readRegister1 == ZIDX) readData1 = '0;
      else if (byp1)             readData1 = writeData;
      else                       readData1 = regs_q[readRegister1];
   end

   always_comb begin
      if (readRegister2 == ZIDX) readData2 = '0;
      else if (byp2)             readData2 = writeData;
      else                       readData2 = regs_q[readRegister2];
   end

   assign wrErr   = wr_err_q;
   assign wrCount = wr_count_q;

endmodule

// File: tb/tb_regfile_core.sv
// tb_regfile_core: directed bench for regfile_core, bypass and no-bypass.
// A reference model is compared against both instances every cycle.
module tb_regfile_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] wrEn = '0;
   logic [63:0] writeData = '0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;

   logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        err_b, err_n;
   logic [15:0] cnt_b, cnt_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_core #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .wrEn(wrEn), .writeData(writeData),
      .readRegister1(ra1), .readRegister2(ra2),
      .readData1(rd1_b), .readData2(rd2_b),
      .wrErr(err_b), .wrCount(cnt_b)
   );

   regfile_core #(.WIDTH(64), .ZERO_REG(31), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .wrEn(wrEn), .writeData(writeData),
      .readRegister1(ra1), .readRegister2(ra2),
      .readData1(rd1_n), .readData2(rd2_n),
      .wrErr(err_n), .wrCount(cnt_n)
   );

   // Reference model
   logic [63:0] m_regs [32];
   logic        m_err;
   logic [15:0] m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_err = 1'b0;
         m_cnt = '0;
      end else if ($countones(wrEn) == 1) begin
         for (int i = 0; i < 31; i++) begin
            if (wrEn[i]) begin
               m_regs[i] = writeData;
               m_cnt     = m_cnt + 16'd1;
            end
         end
      end else if ($countones(wrEn) > 1) begin
         m_err = 1'b1;
      end
   end

   function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd31) return '0;
      if (byp && $countones(wrEn) == 1 && wrEn[a]) return writeData;
      return m_regs[a];
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("m_rd1_b", rd1_b, exp_rd(ra1, 1'b1));
      chk("m_rd2_b", rd2_b, exp_rd(ra2, 1'b1));
      chk("m_rd1_n", rd1_n, exp_rd(ra1, 1'b0));
      chk("m_rd2_n", rd2_n, exp_rd(ra2, 1'b0));
      chk("m_err_b", 64'(err_b), 64'(m_err));
      chk("m_err_n", 64'(err_n), 64'(m_err));
      chk("m_cnt_b", 64'(cnt_b), 64'(m_cnt));
      chk("m_cnt_n", 64'(cnt_n), 64'(m_cnt));
   end

   task automatic drive(input logic [31:0] we, input logic [63:0] d,
                        input logic [4:0] a1, input logic [4:0] a2);
      wrEn      = we;
      writeData = d;
      ra1       = a1;
      ra2       = a2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1: async reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      chk("rst_rd1", rd1_b, 64'h0);
      chk("rst_err", 64'(err_b), 64'h0);
      chk("rst_cnt", 64'(cnt_b), 64'h0);
      #18 rst_n = 1'b1;
      step();

      // 2: write reg 3, read next cycle
      drive(32'd1 << 3, 64'hDEAD_BEEF_0000_0001, 5'd3, 5'd4);
      step();
      drive(32'd0, 64'h0, 5'd3, 5'd4);
      #1;
      chk("wr3_rd1", rd1_b, 64'hDEADBEEF00000001);
      chk("wr3_rd2", rd2_b, 64'h0);
      chk("wr3_cnt", 64'(cnt_b), 64'd1);

      // 3: same-cycle bypass vs. no bypass
      drive(32'd1 << 5, 64'h55, 5'd5, 5'd5);
      #1;
      chk("byp_on", rd1_b, 64'h55);
      chk("byp_off", rd1_n, 64'h0);
      step();
      drive(32'd0, 64'h0, 5'd5, 5'd5);
      #1;
      chk("byp_off_nxt", rd1_n, 64'h55);
      chk("byp_cnt", 64'(cnt_n), 64'd2);

      // 4: zero register write dropped
      drive(32'd1 << 31, '1, 5'd31, 5'd31);
      #1;
      chk("z_byp", rd1_b, 64'h0);
      step();
      drive(32'd0, 64'h0, 5'd31, 5'd3);
      #1;
      chk("z_rd", rd1_b, 64'h0);
      chk("z_cnt", 64'(cnt_b), 64'd2);
      chk("z_err", 64'(err_b), 64'h0);

      // 5: multi-hot is dropped and sticky
      drive(32'd1 << 1, 64'h11, 5'd1, 5'd2);
      step();
      drive(32'd1 << 2, 64'h22, 5'd1, 5'd2);
      step();
      drive(32'h0000_0006, 64'h77, 5'd1, 5'd2);
      #1;
      chk("mh_nobyp", rd1_b, 64'h11);
      step();
      drive(32'd0, 64'h0, 5'd1, 5'd2);
      #1;
      chk("mh_r1", rd1_b, 64'h11);
      chk("mh_r2", rd2_b, 64'h22);
      chk("mh_err", 64'(err_b), 64'd1);
      chk("mh_cnt", 64'(cnt_b), 64'd4);
      drive(32'd1 << 9, 64'h99, 5'd9, 5'd1);
      step();
      drive(32'd0, 64'h0, 5'd9, 5'd1);
      #1;
      chk("mh_hold", 64'(err_b), 64'd1);
      chk("mh_cnt2", 64'(cnt_b), 64'd5);
      #1 rst_n = 1'b0;
      #1;
      chk("mh_clr", 64'(err_b), 64'h0);
      #1 rst_n = 1'b1;

      // 6: counter wrap on reg 7
      step();
      for (int i = 1; i <= 65535; i++) begin
         drive(32'd1 << 7, 64'(i), 5'd7, 5'd0);
         step();
      end
      drive(32'd0, 64'h0, 5'd7, 5'd0);
      #1;
      chk("wrap_ffff", 64'(cnt_b), 64'hFFFF);
      chk("wrap_r7", rd1_b, 64'd65535);
      drive(32'd1 << 7, 64'hA5A5_A5A5_A5A5_A5A5, 5'd7, 5'd0);
      step();
      drive(32'd0, 64'h0, 5'd7, 5'd0);
      #1;
      chk("wrap_0", 64'(cnt_b), 64'h0);
      chk("wrap_last", rd1_b, 64'hA5A5A5A5A5A5A5A5);

      // async reset during a write cycle
      step();
      drive(32'd1 << 7, 64'h1234, 5'd7, 5'd7);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      drive(32'd0, 64'h0, 5'd7, 5'd7);
      #1;
      chk("rstw_r7", rd1_n, 64'h0);
      chk("rstw_cnt", 64'(cnt_n), 64'h0);
      #2 rst_n = 1'b1;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
